mbist_march_ctrl: RTL and testbench
===================================

Name: mbist_march_ctrl

Overview:
- March C- built-in self-test controller that drives the 64x8 single-port SRAM through its native pins (ramaddr, ramin, rwbar, cs) and checks read data on ramout.
- Sits between the test-mode control logic and the SRAM macro; on a start pulse it runs the full march sequence once.
- Reports pass/fail, first-failure diagnostics and a saturating error count.

Parameters:
ADDR_W, 6, SRAM address width (depth = 2**ADDR_W)
DATA_W, 8, SRAM data width
BG, 8'h00, data background used for "0" writes and expects; "1" = ~BG
STOP_ON_FAIL, 0, 1 = abort to DONE on the first mismatch; 0 = run to completion

Ports:
clk  in  1  system clock, all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled only in IDLE or DONE
ramaddr  out  ADDR_W  SRAM address
ramin  out  DATA_W  SRAM write data
rwbar  out  1  1 = read, 0 = write
cs  out  1  SRAM chip select
ramout  in  DATA_W  SRAM read data
busy  out  1  test in progress
done  out  1  test finished; held until the next start
fail  out  1  at least one mismatch seen in this run
fail_addr  out  ADDR_W  address of the first mismatch
fail_data  out  DATA_W  ramout value at the first mismatch
fail_elem  out  3  march element (0-5) of the first mismatch
err_cnt  out  8  mismatch count, saturates at 255

Behaviour:
- Interface decided: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: cs=0, rwbar=1, ramaddr=0, ramin=0, busy=0, done=0, fail=0, fail_addr=0, fail_data=0, fail_elem=0, err_cnt=0. State = IDLE.
- All outputs are registered. ramout is the only combinational input.
- Element sequence, with addresses 0..63 for up and 63..0 for down:
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 down (r0)
- SRAM read timing: the address is registered inside the SRAM, and ramout is valid the cycle after issue only while cs=1 and rwbar=1.
- Each read therefore takes two cycles:
  - RD: cs=1, rwbar=1, ramaddr=A.
  - CMP: same outputs held; ramout is compared to the expected value (BG or ~BG), and the result is captured on the clock edge ending CMP.
- WR: cs=1, rwbar=0, ramaddr=A, ramin = BG or ~BG.
- Per-address cost: M0 = 1 cycle; M1-M4 = 3 cycles (RD, CMP, WR); M5 = 2 cycles. Total 64 + 4*192 + 128 = 960 operation cycles.
- Element advances when the address counter reaches its terminal value (63 up, 0 down) after that address's last operation. No wrap occurs within an element.
- Start: start=1 in IDLE or DONE at edge k clears fail, fail_* and err_cnt, and sets busy=1, done=0. The first M0 write is presented in cycle k+1.
- start while busy is ignored.
- Completion: after the M5 CMP at address 0 → DONE:
  - cs=0, rwbar=1, busy=0, done=1.
  - For a start at edge 0, done=1 from cycle 961.
- Mismatch handling:
  - err_cnt increments (saturating at 255) and fail=1.
  - fail_addr, fail_data and fail_elem are latched only on the first mismatch of a run.
  - If STOP_ON_FAIL=1, go to DONE on the next cycle (cs=0).
- cs is 0 in IDLE and DONE. Never drive rwbar=0 with cs=0 while busy.
- Reset asserted mid-run: all outputs return to their reset values immediately, and the SRAM is left with partial contents. After release, stay IDLE until start.

Test Plan:
- Fault-free SRAM model, start pulse at cycle 0 → cycles 1-64: writes of 8'h00 to addr 0..63. done=1 at cycle 961 with fail=0, err_cnt=0.
- Bit 0 of addr 5 stuck-at-1 (ramout=8'h01 on reads) → fail=1, fail_addr=5, fail_data=8'h01, fail_elem=1, err_cnt=3 (fails in M1, M3, M5).
- Same fault with STOP_ON_FAIL=1 → mismatch at the CMP in cycle 81, done=1 and cs=0 from cycle 82, err_cnt=1.
- Protocol check → M3 first op is RD at addr 63. Every CMP cycle holds rwbar=1 and cs=1. cs=0 throughout IDLE/DONE.
- start pulsed at cycle 300 (busy) → ignored, done still at 961. A new start in DONE clears fail/err_cnt and reruns.
- rst_n low at cycle 500 (M2) → cs=0, busy=0, done=0 asynchronously. No activity until the next start.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
//   March C- BIST controller for a single-port SRAM with a registered read
//   address. A start pulse in IDLE or DONE runs the six march elements once
//   and then parks in DONE until the next start.
//
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      run request, honoured only in IDLE or DONE
//   ramaddr    SRAM address
//   ramin      SRAM write data
//   rwbar      1 = read, 0 = write
//   cs         SRAM chip select
//   ramout     SRAM read data (valid the cycle after a read is issued)
//   busy       test in progress
//   done       test finished, held until the next start
//   fail       at least one mismatch seen in this run
//   fail_addr  address of the first mismatch
//   fail_data  ramout value at the first mismatch
//   fail_elem  march element (0-5) of the first mismatch
//   err_cnt    mismatch count, saturating at 255
module mbist_march_ctrl #(
    parameter int unsigned       ADDR_W       = 6,
    parameter int unsigned       DATA_W       = 8,
    parameter logic [DATA_W-1:0] BG           = 8'h00,
    parameter int unsigned       STOP_ON_FAIL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramin,
    output logic              rwbar,
    output logic              cs,
    input  logic [DATA_W-1:0] ramout,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [2:0]        fail_elem,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CMP,
        S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  elem;

    logic              up;        // elements 0-2 ascend, 3-5 descend
    logic              last_addr; // terminal address of the current element
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] wr_data;
    logic              mismatch;

    always_comb begin
        up        = (elem <= 3'd2);
        last_addr = up ? (ramaddr == '1) : (ramaddr == '0);
        // Reads of "1" happen in M2 and M4; writes of "1" in M1 and M3.
        exp_data  = (elem == 3'd2 || elem == 3'd4) ? ~BG : BG;
        wr_data   = (elem == 3'd1 || elem == 3'd3) ? ~BG : BG;
        mismatch  = (ramout != exp_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            elem      <= '0;
            ramaddr   <= '0;
            ramin     <= '0;
            rwbar     <= 1'b1;
            cs        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_elem <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_WR;
                        elem      <= '0;
                        ramaddr   <= '0;
                        ramin     <= BG;
                        rwbar     <= 1'b0;
                        cs        <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        fail_elem <= '0;
                        err_cnt   <= '0;
                    end
                end

                // WR is the last operation at an address for M0-M4.
                S_WR: begin
                    rwbar <= 1'b1;
                    state <= S_RD;
                    if (last_addr) begin
                        elem    <= elem + 3'd1;
                        ramaddr <= (elem >= 3'd2) ? '1 : '0;
                    end else begin
                        ramaddr <= up ? ramaddr + 1'b1 : ramaddr - 1'b1;
                        if (elem == 3'd0) begin
                            rwbar <= 1'b0;
                            state <= S_WR;
                        end
                    end
                end

                S_RD: begin
                    state <= S_CMP;
                end

                S_CMP: begin
                    if (mismatch) begin
                        fail <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        if (!fail) begin
                            fail_addr <= ramaddr;
                            fail_data <= ramout;
                            fail_elem <= elem;
                        end
                    end
                    if ((mismatch && STOP_ON_FAIL != 0) ||
                        (elem == 3'd5 && ramaddr == '0)) begin
                        state <= S_DONE;
                        cs    <= 1'b0;
                        rwbar <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (elem == 3'd5) begin
                        ramaddr <= ramaddr - 1'b1;
                        state   <= S_RD;
                    end else begin
                        ramin <= wr_data;
                        rwbar <= 1'b0;
                        state <= S_WR;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cs    <= 1'b0;
                    rwbar <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: two instances share clock, reset and
// start. u0 runs with STOP_ON_FAIL=0 against a model SRAM whose stuck-at
// fault can be switched on; u1 runs with STOP_ON_FAIL=1 against a model with
// bit 0 of address 5 permanently stuck at 1.
module tb_mbist_march_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic fault0 = 1'b0;

    logic [5:0] ramaddr0, ramaddr1, fail_addr0, fail_addr1;
    logic [7:0] ramin0, ramin1, ramout0, ramout1, fail_data0, fail_data1;
    logic [7:0] err_cnt0, err_cnt1;
    logic [2:0] fail_elem0, fail_elem1;
    logic rwbar0, rwbar1, cs0, cs1, busy0, busy1, done0, done1, fail0, fail1;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    time t0 = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8), .BG(8'h00), .STOP_ON_FAIL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ramaddr(ramaddr0), .ramin(ramin0), .rwbar(rwbar0), .cs(cs0),
        .ramout(ramout0), .busy(busy0), .done(done0), .fail(fail0),
        .fail_addr(fail_addr0), .fail_data(fail_data0),
        .fail_elem(fail_elem0), .err_cnt(err_cnt0)
    );

    mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8), .BG(8'h00), .STOP_ON_FAIL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ramaddr(ramaddr1), .ramin(ramin1), .rwbar(rwbar1), .cs(cs1),
        .ramout(ramout1), .busy(busy1), .done(done1), .fail(fail1),
        .fail_addr(fail_addr1), .fail_data(fail_data1),
        .fail_elem(fail_elem1), .err_cnt(err_cnt1)
    );

    // SRAM models: write on the edge, read address registered on the edge.
    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];
    logic [5:0] aq0 = '0;
    logic [5:0] aq1 = '0;

    always @(posedge clk) begin
        if (cs0) begin
            if (!rwbar0) mem0[ramaddr0] <= ramin0;
            else         aq0 <= ramaddr0;
        end
        if (cs1) begin
            if (!rwbar1) mem1[ramaddr1] <= ramin1;
            else         aq1 <= ramaddr1;
        end
    end

    assign ramout0 = mem0[aq0] | {7'b0, fault0 && (aq0 == 6'd5)};
    assign ramout1 = mem1[aq1] | {7'b0, aq1 == 6'd5};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pulse start so that it is sampled on edge 0; t0 marks that edge.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1 start = 1'b0;
    endtask

    // Move to the middle (falling edge) of cycle c, i.e. after edge c-1.
    task automatic at_cycle(input int unsigned c);
        time target;
        target = t0 + (c - 1) * 10 + 5;
        if (target > $time) #(target - $time);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 8'hA5;
            mem1[i] = 8'hA5;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", cs0, 0);
        check("rst_rwbar", rwbar0, 1);
        check("rst_busy_done", {busy0, done0, fail0}, 0);
        check("rst_err", err_cnt0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_cs", cs0, 0);

        // Run 1: fault-free u0, stop-on-fail u1
        do_start();
        at_cycle(1);
        check("c1_wr0", {cs0, rwbar0, ramaddr0, ramin0}, {1'b1, 1'b0, 6'd0, 8'h00});
        check("c1_busy", {busy0, done0}, 2'b10);
        at_cycle(64);
        check("c64_wr63", {cs0, rwbar0, ramaddr0}, {1'b1, 1'b0, 6'd63});
        at_cycle(65);
        check("c65_rd0", {cs0, rwbar0, ramaddr0}, {1'b1, 1'b1, 6'd0});
        at_cycle(66);
        check("c66_cmp0", {cs0, rwbar0, ramaddr0}, {1'b1, 1'b1, 6'd0});
        at_cycle(67);
        check("c67_wr1", {cs0, rwbar0, ramaddr0, ramin0}, {1'b1, 1'b0, 6'd0, 8'hFF});
        at_cycle(81);
        check("u1_c81_cmp5", {cs1, rwbar1, ramaddr1, done1}, {1'b1, 1'b1, 6'd5, 1'b0});
        at_cycle(82);
        check("u1_c82_done", {cs1, busy1, done1, fail1}, 4'b0011);
        check("u1_err", err_cnt1, 1);
        check("u1_fail_info", {fail_addr1, fail_data1, fail_elem1}, {6'd5, 8'h01, 3'd1});
        at_cycle(300);
        start = 1'b1;
        at_cycle(301);
        start = 1'b0;
        check("c301_busy", {busy0, done0}, 2'b10);
        at_cycle(449);
        check("m3_first_rd63", {cs0, rwbar0, ramaddr0}, {1'b1, 1'b1, 6'd63});
        at_cycle(450);
        check("m3_cmp63", {cs0, rwbar0, ramaddr0}, {1'b1, 1'b1, 6'd63});
        at_cycle(960);
        check("c960_m5_cmp0", {cs0, rwbar0, ramaddr0, done0}, {1'b1, 1'b1, 6'd0, 1'b0});
        at_cycle(961);
        check("c961_done", {cs0, busy0, done0}, 3'b001);
        check("c961_clean", {fail0, err_cnt0}, 9'd0);
        at_cycle(970);
        check("done_hold", {cs0, rwbar0, done0}, 3'b011);

        // Run 2: stuck-at-1 on u0, restart from DONE
        fault0 = 1'b1;
        do_start();
        at_cycle(1);
        check("r2_c1_busy", {busy0, done0}, 2'b10);
        at_cycle(961);
        check("r2_done", {done0, fail0}, 2'b11);
        check("r2_err", err_cnt0, 3);
        check("r2_fail_info", {fail_addr0, fail_data0, fail_elem0}, {6'd5, 8'h01, 3'd1});

        // Run 3: fault off, restart clears diagnostics, reset in M2
        fault0 = 1'b0;
        do_start();
        at_cycle(1);
        check("r3_clear", {fail0, err_cnt0, fail_addr0, fail_data0, fail_elem0}, 0);
        at_cycle(500);
        check("r3_c500_busy", {cs0, busy0}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("r3_async_rst", {cs0, busy0, done0, rwbar0}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("r3_idle_after_rst", {cs0, busy0, done0}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
